// File: rtl/utopia_phy_cell_source_if.sv
// UTOPIA Level-1 receive-side bundle between the PHY cell source and its users:
// local byte-push port plus the registered UTOPIA cell stream toward the core.
interface utopia_phy_cell_source_if #(
    parameter int IfWidth = 8,
    parameter int DEPTH   = 4
);
    localparam int CntW = $clog2(DEPTH + 1);

    logic               wr_valid;
    logic [IfWidth-1:0] wr_data;
    logic               wr_sop;
    logic               wr_ready;
    logic               wr_err;
    logic               en;
    logic [IfWidth-1:0] data;
    logic               soc;
    logic               clav;
    logic [CntW-1:0]    cell_count;

    modport master (
        input  wr_valid, wr_data, wr_sop, en,
        output wr_ready, wr_err, data, soc, clav, cell_count
    );

    modport slave (
        output wr_valid, wr_data, wr_sop, en,
        input  wr_ready, wr_err, data, soc, clav, cell_count
    );
endinterface

// File: rtl/utopia_phy_cell_source.sv
// PHY-side UTOPIA Level-1 cell transmitter: buffers DEPTH whole cells pushed bytewise
// and streams them out one byte per en-low cycle with registered data/soc.
module utopia_phy_cell_source #(
    parameter int IfWidth    = 8,
    parameter int CELL_BYTES = 53,
    parameter int DEPTH      = 4
) (
    input  logic                     clk_in,
    input  logic                     reset,
    utopia_phy_cell_source_if.master bus
);
    localparam int PtrW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ByteW    = $clog2(CELL_BYTES);
    localparam int CntW     = $clog2(DEPTH + 1);
    localparam int MemWords = DEPTH * CELL_BYTES;
    localparam int AddrW    = $clog2(MemWords);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state;
    logic [IfWidth-1:0] mem [MemWords];
    logic [PtrW-1:0]    wr_ptr;
    logic [PtrW-1:0]    rd_ptr;
    logic [ByteW-1:0]   wr_cnt;
    logic [ByteW-1:0]   rd_cnt;
    logic [CntW-1:0]    cell_count;
    logic [IfWidth-1:0] data_p0;
    logic               soc_p0;
    logic               wr_err_p0;

    logic               wr_ready;
    logic               wr_acc;
    logic               wr_restart;
    logic               wr_drop;
    logic               wr_store;
    logic               wr_commit;
    logic [ByteW-1:0]   wr_off;
    logic [AddrW-1:0]   wr_addr;
    logic               rd_start;
    logic               rd_next;
    logic               rd_last;
    logic [AddrW-1:0]   rd_addr;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [AddrW-1:0] slot_addr(input logic [PtrW-1:0]  p,
                                                   input logic [ByteW-1:0] o);
        return AddrW'(p) * AddrW'(CELL_BYTES) + AddrW'(o);
    endfunction

    assign wr_ready = (cell_count < CntW'(DEPTH));

    // A sop in mid-cell restarts the slot at byte 0; a non-sop at cell start is discarded.
    always_comb begin
        wr_acc     = bus.wr_valid && wr_ready;
        wr_restart = wr_acc && bus.wr_sop && (wr_cnt != '0);
        wr_drop    = wr_acc && !bus.wr_sop && (wr_cnt == '0);
        wr_store   = wr_acc && !wr_drop;
        wr_off     = wr_restart ? '0 : wr_cnt;
        wr_commit  = wr_store && (wr_off == ByteW'(CELL_BYTES - 1));
        wr_addr    = slot_addr(wr_ptr, wr_off);
        rd_start   = (state == IDLE) && !bus.en && (cell_count != '0);
        rd_next    = (state == SEND) && !bus.en;
        rd_last    = rd_next && (rd_cnt == ByteW'(CELL_BYTES - 1));
        rd_addr    = slot_addr(rd_ptr, rd_start ? '0 : rd_cnt);
    end

    always_ff @(posedge clk_in) begin
        if (wr_store) begin
            mem[wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            cell_count <= '0;
            data_p0    <= '0;
            soc_p0     <= 1'b0;
            wr_err_p0  <= 1'b0;
        end else begin
            wr_err_p0 <= wr_restart || wr_drop;
            if (wr_store) begin
                wr_cnt <= wr_commit ? '0 : wr_off + 1'b1;
            end
            if (wr_commit) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end

            soc_p0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (rd_start) begin
                        data_p0 <= mem[rd_addr];
                        soc_p0  <= 1'b1;
                        rd_cnt  <= ByteW'(1);
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (rd_next) begin
                        data_p0 <= mem[rd_addr];
                        if (rd_last) begin
                            rd_cnt <= '0;
                            rd_ptr <= ptr_inc(rd_ptr);
                            state  <= IDLE;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Commit and release in the same cycle leave the occupancy unchanged.
            case ({wr_commit, rd_last})
                2'b10:   cell_count <= cell_count + 1'b1;
                2'b01:   cell_count <= cell_count - 1'b1;
                default: cell_count <= cell_count;
            endcase
        end
    end

    // The cell currently being sent is no longer advertised as available.
    assign bus.clav       = (state == SEND) ? (cell_count > CntW'(1)) : (cell_count != '0);
    assign bus.wr_ready   = wr_ready;
    assign bus.wr_err     = wr_err_p0;
    assign bus.data       = data_p0;
    assign bus.soc        = soc_p0;
    assign bus.cell_count = cell_count;
endmodule

// File: tb/tb_utopia_phy_cell_source.sv
// Bench for utopia_phy_cell_source: scenario tasks plus a queue-based cell model
// that predicts every output cycle by cycle.
module tb_utopia_phy_cell_source;
    localparam int W  = 8;
    localparam int CB = 53;
    localparam int DP = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    utopia_phy_cell_source_if #(.IfWidth(W), .DEPTH(DP)) bus ();

    utopia_phy_cell_source #(.IfWidth(W), .CELL_BYTES(CB), .DEPTH(DP)) dut (
        .clk_in (clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: committed bytes in send order, the partial cell, and read progress.
    logic [7:0] cq[$];
    logic [7:0] partial[$];
    logic [7:0] got[$];
    logic [7:0] exp_seq[$];
    logic [7:0] m_data = 8'h00;
    bit         m_soc, m_err, m_acc, m_xfer, m_sending;
    int         m_count, m_sent;

    function automatic bit m_clav();
        return m_sending ? (m_count > 1) : (m_count > 0);
    endfunction

    function automatic logic [14:0] expv();
        return {m_data, m_soc, m_clav(), 3'(m_count), (m_count < DP), m_err};
    endfunction

    function automatic logic [14:0] obs();
        return {bus.data, bus.soc, bus.clav, bus.cell_count, bus.wr_ready, bus.wr_err};
    endfunction

    task automatic model_step();
        bit commit, free;
        commit = 0;
        free   = 0;
        m_xfer = 0;
        m_acc  = 0;
        if (!rst_n) begin
            m_count = 0; m_sent = 0; m_sending = 0;
            cq.delete(); partial.delete();
            m_data = 8'h00; m_soc = 0; m_err = 0;
            return;
        end
        m_err = 0;
        m_acc = bus.wr_valid && (m_count < DP);
        if (m_acc) begin
            if (bus.wr_sop) begin
                if (partial.size() != 0) m_err = 1;
                partial.delete();
                partial.push_back(bus.wr_data);
            end else if (partial.size() == 0) begin
                m_err = 1;
            end else begin
                partial.push_back(bus.wr_data);
            end
        end
        m_soc = 0;
        if (!bus.en) begin
            if (m_sending) begin
                m_data = cq.pop_front();
                m_sent++;
                m_xfer = 1;
                if (m_sent == CB) begin
                    m_sending = 0;
                    free = 1;
                end
            end else if (m_count > 0) begin
                m_data = cq.pop_front();
                m_soc = 1;
                m_sending = 1;
                m_sent = 1;
                m_xfer = 1;
            end
        end
        if (partial.size() == CB) begin
            commit = 1;
            foreach (partial[k]) cq.push_back(partial[k]);
            partial.delete();
        end
        m_count = m_count + int'(commit) - int'(free);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_xfer) got.push_back(bus.data);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        got.delete();
        exp_seq.delete();
    endtask

    task automatic push_cell(input logic [7:0] base);
        for (int i = 0; i < CB; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_sop   = (i == 0);
            bus.wr_data  = base + 8'(i);
            exp_seq.push_back(base + 8'(i));
            tick();
        end
        bus.wr_valid = 1'b0;
        bus.wr_sop   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.wr_valid = 1'b0;
        bus.en = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (obs() !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_values got=%h want=%h", obs(), {8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_cell();
        bit ok;
        do_reset();
        bus.en = 1'b0;
        for (int i = 0; i < CB; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_sop   = (i == 0);
            bus.wr_data  = 8'(i);
            tick();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL single_push cyc=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        bus.wr_valid = 1'b0;
        n_cmp++;
        if (bus.clav !== 1'b1) begin
            n_bad++;
            $display("FAIL single_clav_after_commit got=%b want=1", bus.clav);
        end
        tick();
        n_cmp++;
        if ({bus.data, bus.soc, bus.clav} !== {8'h00, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL single_byte0 got data=%h soc=%b clav=%b want 00/1/0", bus.data, bus.soc, bus.clav);
        end
        for (int i = 1; i < CB; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL single_read cyc=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        ok = (got.size() == CB) && (bus.cell_count == 0);
        foreach (got[k]) if (got[k] !== 8'(k)) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL single_sequence got %0d bytes count=%0d want 53 bytes count=0", got.size(), bus.cell_count);
        end
    endtask

    task automatic test_en_alternate();
        bit ok;
        logic [7:0] prev;
        do_reset();
        push_cell(8'h00);
        prev = bus.data;
        for (int k = 0; k < 2 * CB; k++) begin
            bus.en = k[0];
            tick();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL alt_cycle k=%0d got=%h want=%h", k, obs(), expv());
            end
            if (k[0]) begin
                n_cmp++;
                if (bus.data !== prev || bus.soc !== 1'b0) begin
                    n_bad++;
                    $display("FAIL alt_hold k=%0d got data=%h soc=%b want %h/0", k, bus.data, bus.soc, prev);
                end
            end
            prev = bus.data;
        end
        ok = (got.size() == CB) && (bus.cell_count == 0);
        foreach (got[k]) if (got[k] !== 8'(k)) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL alt_sequence got %0d bytes want 53", got.size());
        end
    endtask

    task automatic test_full();
        int idx;
        bit seen, ok;
        do_reset();
        for (int c = 0; c < DP; c++) push_cell(8'(c * 60));
        n_cmp++;
        if ({bus.cell_count, bus.wr_ready} !== {3'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL full_state got count=%0d ready=%b want 4/0", bus.cell_count, bus.wr_ready);
        end
        bus.wr_valid = 1'b1;
        bus.wr_sop = 1'b1;
        bus.wr_data = 8'd200;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_cmp++;
            if (obs() !== expv() || bus.cell_count !== 3'd4) begin
                n_bad++;
                $display("FAIL full_ignore i=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        idx = 0;
        seen = 0;
        bus.en = 1'b0;
        for (int cyc = 0; cyc < 800 && !(idx == CB && m_count == 0); cyc++) begin
            bus.wr_valid = (idx < CB);
            bus.wr_sop = (idx == 0);
            bus.wr_data = 8'(200 + idx);
            tick();
            if (m_acc) begin
                exp_seq.push_back(8'(200 + idx));
                idx++;
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL full_drain cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
            if (got.size() == CB && !seen) begin
                seen = 1;
                n_cmp++;
                if (bus.wr_ready !== 1'b1 || bus.data !== 8'd52) begin
                    n_bad++;
                    $display("FAIL full_ready_reassert got ready=%b data=%h want 1/34", bus.wr_ready, bus.data);
                end
            end
        end
        bus.wr_valid = 1'b0;
        ok = (got.size() == exp_seq.size()) && (got.size() == 5 * CB);
        foreach (got[k]) if (k < exp_seq.size() && got[k] !== exp_seq[k]) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL full_sequence got %0d bytes want %0d", got.size(), 5 * CB);
        end
    endtask

    task automatic test_framing();
        bit ok;
        int bound;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_sop = (i == 0);
            bus.wr_data = 8'(8'h80 + i);
            tick();
        end
        bus.wr_sop = 1'b1;
        bus.wr_data = 8'h40;
        tick();
        n_cmp++;
        if (bus.wr_err !== 1'b1) begin
            n_bad++;
            $display("FAIL framing_restart_err got=%b want=1", bus.wr_err);
        end
        for (int i = 1; i < CB; i++) begin
            bus.wr_sop = 1'b0;
            bus.wr_data = 8'(8'h40 + i);
            tick();
            n_cmp++;
            if (obs() !== expv() || (i == 1 && bus.wr_err !== 1'b0)) begin
                n_bad++;
                $display("FAIL framing_push i=%0d got=%h want=%h", i, obs(), expv());
            end
        end
        bus.wr_data = 8'h99;
        tick();
        n_cmp++;
        if ({bus.wr_err, bus.cell_count} !== {1'b1, 3'd1}) begin
            n_bad++;
            $display("FAIL framing_stray got err=%b count=%0d want 1/1", bus.wr_err, bus.cell_count);
        end
        bus.wr_valid = 1'b0;
        bus.en = 1'b0;
        bound = 0;
        while (m_count > 0 && bound < 200) begin
            tick();
            bound++;
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL framing_read cyc=%0d got=%h want=%h", bound, obs(), expv());
            end
        end
        ok = (got.size() == CB);
        foreach (got[k]) if (got[k] !== 8'(8'h40 + k)) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL framing_sequence got %0d bytes want 53 starting 40", got.size());
        end
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        int bound;
        do_reset();
        push_cell(8'h00);
        push_cell(8'h60);
        bus.en = 1'b0;
        bound = 0;
        while (got.size() < 30 && bound < 100) begin
            tick();
            bound++;
        end
        n_cmp++;
        if (bus.data !== 8'd29) begin
            n_bad++;
            $display("FAIL midsend_progress got=%h want=1d", bus.data);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (obs() !== {8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL midsend_reset got=%h want=%h", obs(), {8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0});
        end
        rst_n = 1'b1;
        bus.en = 1'b1;
        got.delete();
        push_cell(8'hA0);
        n_cmp++;
        if (bus.cell_count !== 3'd1) begin
            n_bad++;
            $display("FAIL midsend_fresh_count got=%0d want=1", bus.cell_count);
        end
        bus.en = 1'b0;
        tick();
        n_cmp++;
        if ({bus.data, bus.soc} !== {8'hA0, 1'b1}) begin
            n_bad++;
            $display("FAIL midsend_fresh_byte0 got data=%h soc=%b want a0/1", bus.data, bus.soc);
        end
        bound = 0;
        while (got.size() < CB && bound < 100) begin
            tick();
            bound++;
        end
        ok = (got.size() == CB);
        foreach (got[k]) if (got[k] !== 8'(8'hA0 + k)) ok = 0;
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL midsend_fresh_sequence got %0d bytes want 53", got.size());
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bus.en = ($urandom_range(0, 9) < 4);
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_sop = (partial.size() == 0);
            if ($urandom_range(0, 59) == 0) bus.wr_sop = ~bus.wr_sop;
            bus.wr_data = 8'($urandom);
            tick();
            n_cmp++;
            if (obs() !== expv()) begin
                n_bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs(), expv());
            end
        end
        bus.wr_valid = 1'b0;
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_sop = 1'b0;
        bus.wr_data = 8'h00;
        bus.en = 1'b1;
        test_reset();
        test_single_cell();
        test_en_alternate();
        test_full();
        test_framing();
        test_reset_mid_send();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
